// File: rtl/result_drain.sv
// Result drain: three per-channel row FIFOs, fixed-priority a>b>c arbiter,
// row-to-beat serialiser on a valid/ready stream, sticky overflow flags and
// a drain-complete level. Optional beat parity under RESULT_DRAIN_PARITY_EN.
module result_drain #(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 32,
    parameter int SRAM_DATA_WIDTH   = 64,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                      clk,
    input  logic                                      srstn,
    input  logic                                      wr_en_a,
    input  logic                                      wr_en_b,
    input  logic                                      wr_en_c,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   wdata_a,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   wdata_b,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   wdata_c,
    input  logic [5:0]                                waddr_a,
    input  logic [5:0]                                waddr_b,
    input  logic [5:0]                                waddr_c,
    input  logic                                      tpu_done,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [SRAM_DATA_WIDTH-1:0]                m_data,
    output logic [1:0]                                m_bank,
    output logic [5:0]                                m_addr,
    output logic                                      m_last,
    output logic [2:0]                                ovf_err,
    output logic                                      drain_done
`ifdef RESULT_DRAIN_PARITY_EN
    ,
    output logic                                      m_parity
`endif
);

    localparam int ROW   = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int BEATS = ROW / SRAM_DATA_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int ENT   = ROW + 6;

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t           state_q, state_d;

    logic [2:0]       wr_en;
    logic [ENT-1:0]   wentry [3];
    logic [ENT-1:0]   head   [3];
    logic [ENT-1:0]   mem_q  [3][FIFO_DEPTH];
    logic [PW:0]      wptr_q [3];
    logic [PW:0]      wptr_d [3];
    logic [PW:0]      rptr_q [3];
    logic [PW:0]      rptr_d [3];
    logic [2:0]       full, empty, push, pop;
    logic [2:0]       ovf_q, ovf_d;

    logic [1:0]       sel_bank;
    logic [ENT-1:0]   sel_entry;
    logic [ROW-1:0]   row_q, row_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [1:0]       bank_q, bank_d;
    logic [5:0]       addr_q, addr_d;
    logic             last_beat, fire;
    logic             done_seen_q, done_seen_d;
    logic             drain_q, drain_d;

    // Gather the three write ports into indexable form.
    always_comb begin
        wr_en     = {wr_en_c, wr_en_b, wr_en_a};
        wentry[0] = {waddr_a, wdata_a};
        wentry[1] = {waddr_b, wdata_b};
        wentry[2] = {waddr_c, wdata_c};
    end

    // FIFO status, push acceptance (full+pop still accepts) and pointer update.
    always_comb begin
        ovf_d = ovf_q;
        for (int c = 0; c < 3; c++) begin
            empty[c]  = (wptr_q[c] == rptr_q[c]);
            full[c]   = (wptr_q[c][PW] != rptr_q[c][PW]) &&
                        (wptr_q[c][PW-1:0] == rptr_q[c][PW-1:0]);
            push[c]   = wr_en[c] && (!full[c] || pop[c]);
            head[c]   = mem_q[c][rptr_q[c][PW-1:0]];
            wptr_d[c] = push[c] ? wptr_q[c] + (PW+1)'(1) : wptr_q[c];
            rptr_d[c] = pop[c]  ? rptr_q[c] + (PW+1)'(1) : rptr_q[c];
            if (wr_en[c] && full[c] && !pop[c]) begin
                ovf_d[c] = 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c][PW-1:0]] <= wentry[c];
            end
        end
    end

    // FIFO pointers and sticky overflow flags.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            for (int c = 0; c < 3; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
            end
            ovf_q <= ovf_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign fire      = m_valid && m_ready;

    // FSM next state: start a row when any FIFO holds one, end on last beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (|(~empty)) state_d = SEND;
            SEND: if (fire && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: fixed-priority pop in IDLE, beat valid in SEND.
    always_comb begin
        m_valid  = 1'b0;
        m_last   = 1'b0;
        pop      = 3'b000;
        sel_bank = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (!empty[0]) begin
                    pop      = 3'b001;
                    sel_bank = 2'd0;
                end else if (!empty[1]) begin
                    pop      = 3'b010;
                    sel_bank = 2'd1;
                end else if (!empty[2]) begin
                    pop      = 3'b100;
                    sel_bank = 2'd2;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_last  = last_beat;
            end
            default: ;
        endcase
    end

    // Head entry of the channel chosen by the arbiter.
    always_comb begin
        sel_entry = head[0];
        case (sel_bank)
            2'd1:    sel_entry = head[1];
            2'd2:    sel_entry = head[2];
            default: sel_entry = head[0];
        endcase
    end

    // Serialiser next state: load on pop, shift right one beat per transfer.
    always_comb begin
        row_d  = row_q;
        beat_d = beat_q;
        bank_d = bank_q;
        addr_d = addr_q;
        if (|pop) begin
            {addr_d, row_d} = sel_entry;
            beat_d          = '0;
            bank_d          = sel_bank;
        end else if (fire) begin
            row_d  = row_q >> SRAM_DATA_WIDTH;
            beat_d = beat_q + BW'(1);
        end
    end

    // Serialiser registers.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            row_q  <= '0;
            beat_q <= '0;
            bank_q <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            beat_q <= beat_d;
            bank_q <= bank_d;
            addr_q <= addr_d;
        end
    end

    // Completion: done latched, then idle with empty buffers and no writes.
    always_comb begin
        done_seen_d = done_seen_q | tpu_done;
        drain_d     = done_seen_q && (state_q == IDLE) &&
                      (&empty) && !(|wr_en);
    end

    // Completion registers.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            done_seen_q <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            done_seen_q <= done_seen_d;
            drain_q     <= drain_d;
        end
    end

    assign m_data     = row_q[SRAM_DATA_WIDTH-1:0];
    assign m_bank     = bank_q;
    assign m_addr     = addr_q;
    assign ovf_err    = ovf_q;
    assign drain_done = drain_q;

`ifdef RESULT_DRAIN_PARITY_EN
    assign m_parity = m_valid & (^m_data);
`endif

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: directed scenarios plus random traffic, checked by
// a beat monitor against per-bank expected-row queues.
module tb_result_drain;

    localparam int AS    = 32;
    localparam int OW    = 32;
    localparam int SW    = 64;
    localparam int FD    = 4;
    localparam int ROW   = AS * OW;
    localparam int BEATS = ROW / SW;

    typedef struct packed {
        logic [5:0]     addr;
        logic [ROW-1:0] data;
    } row_t;

    logic           clk;
    logic           srstn;
    logic [2:0]     wr_en;
    logic [ROW-1:0] wdata [3];
    logic [5:0]     waddr [3];
    logic           tpu_done;
    logic           m_valid;
    logic           m_ready;
    logic [SW-1:0]  m_data;
    logic [1:0]     m_bank;
    logic [5:0]     m_addr;
    logic           m_last;
    logic [2:0]     ovf_err;
    logic           drain_done;
`ifdef RESULT_DRAIN_PARITY_EN
    logic           m_parity;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mode = 0;
    int   e0 = 0;
    row_t exp_q [3][$];
    int   log_bank[$];
    int   log_cyc[$];
    int   mbeat = 0;
    row_t cur;
    bit   have = 0;
    logic [1:0]  rbank = '0;
    bit   prev_stall = 0;
    bit   prev_valid = 0;
    bit   prev_dd = 0;
    logic [72:0] snap = '0;
    int   last_xfer_cyc = -1;
    int   dd_rise_cyc = -1;

    result_drain #(
        .ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(OW),
        .SRAM_DATA_WIDTH(SW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .srstn(srstn),
        .wr_en_a(wr_en[0]), .wr_en_b(wr_en[1]), .wr_en_c(wr_en[2]),
        .wdata_a(wdata[0]), .wdata_b(wdata[1]), .wdata_c(wdata[2]),
        .waddr_a(waddr[0]), .waddr_b(waddr[1]), .waddr_c(waddr[2]),
        .tpu_done(tpu_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_bank(m_bank), .m_addr(m_addr), .m_last(m_last),
        .ovf_err(ovf_err), .drain_done(drain_done)
`ifdef RESULT_DRAIN_PARITY_EN
        , .m_parity(m_parity)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern: 0 off, 1 on, 2 toggle, 3 random.
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int logb(input int i);
        return (i < log_bank.size()) ? log_bank[i] : -1;
    endfunction

    function automatic int logc(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1;
    endfunction

    function automatic logic [ROW-1:0] rnd_row();
        logic [ROW-1:0] r;
        for (int i = 0; i < ROW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: reassemble beats into rows and compare with the expected queues.
    always @(negedge clk) begin
        if (!srstn) begin
            for (int c = 0; c < 3; c++) exp_q[c].delete();
            mbeat      = 0;
            have       = 0;
            prev_stall = 0;
            prev_valid = 0;
            prev_dd    = 0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {m_valid, m_bank, m_addr, m_data}, snap);
            if (m_valid && !prev_valid) begin
                log_bank.push_back(int'(m_bank));
                log_cyc.push_back(cyc);
            end
            if (m_valid) chk("done_while_valid", drain_done, 1'b0);
`ifdef RESULT_DRAIN_PARITY_EN
            chk("parity", m_parity, m_valid ? ^m_data : 1'b0);
`endif
            if (m_valid && m_ready) begin
                if (mbeat == 0) begin
                    chk("row_expected", exp_q[m_bank].size() != 0, 1'b1);
                    have = (exp_q[m_bank].size() != 0);
                    if (have) cur = exp_q[m_bank].pop_front();
                    rbank = m_bank;
                end else begin
                    chk("bank_const", m_bank, rbank);
                end
                if (have) begin
                    chk("beat_addr", m_addr, cur.addr);
                    chk("beat_data", m_data, cur.data[mbeat*SW +: SW]);
                end
                chk("beat_last", m_last, mbeat == BEATS - 1);
                if (m_last) last_xfer_cyc = cyc;
                mbeat = (mbeat == BEATS - 1) ? 0 : mbeat + 1;
            end
            if (drain_done && !prev_dd) dd_rise_cyc = cyc;
            prev_stall = m_valid && !m_ready;
            snap       = {m_valid, m_bank, m_addr, m_data};
            prev_valid = m_valid;
            prev_dd    = drain_done;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stage(input int ch, input logic [5:0] a,
                         input logic [ROW-1:0] d, input bit keep);
        row_t r;
        wr_en[ch] = 1'b1;
        waddr[ch] = a;
        wdata[ch] = d;
        r.addr = a;
        r.data = d;
        if (keep) exp_q[ch].push_back(r);
    endtask

    task automatic commit();
        cycles(1);
        e0    = cyc;
        wr_en = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
                exp_q[2].size() != 0 || mbeat != 0 || m_valid) && n < 3000) begin
            cycles(1);
            n++;
        end
        chk("drain_timeout", n < 3000, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [ROW-1:0] r;
        logic [3:0]     kk;
        int base, n, t1e0;
        srstn    = 1;
        wr_en    = '0;
        tpu_done = 0;
        m_ready  = 0;
        for (int c = 0; c < 3; c++) begin
            wdata[c] = '0;
            waddr[c] = '0;
        end
        #2 srstn = 0;
        #1;
        chk("reset_outs", {m_valid, m_last, m_bank, m_addr, m_data,
                           ovf_err, drain_done}, '0);
        cycles(2);
        srstn = 1;

        // single row on a, beat k = hex digit k repeated
        mode = 1;
        cycles(2);
        for (int k = 0; k < BEATS; k++) begin
            kk = 4'(k);
            r[k*SW +: SW] = {16{kk}};
        end
        base = log_bank.size();
        stage(0, 6'd5, r, 1);
        commit();
        t1e0 = e0;
        wait_drain();
        chk("t1_bank", logb(base), 0);
        chk("t1_latency", logc(base), t1e0 + 1);
        chk("t1_no_done", drain_done, 1'b0);

        // simultaneous a/b/c
        base = log_bank.size();
        stage(0, 6'd1, rnd_row(), 1);
        stage(1, 6'd2, rnd_row(), 1);
        stage(2, 6'd3, rnd_row(), 1);
        commit();
        t1e0 = e0;
        wait_drain();
        chk("t2_order0", logb(base), 0);
        chk("t2_order1", logb(base + 1), 1);
        chk("t2_order2", logb(base + 2), 2);
        chk("t2_first", logc(base), t1e0 + 1);
        chk("t2_gap_ab", logc(base + 1) - logc(base), BEATS + 1);
        chk("t2_gap_bc", logc(base + 2) - logc(base + 1), BEATS + 1);

        // toggling back-pressure
        mode = 2;
        cycles(1);
        stage(0, 6'd7, rnd_row(), 1);
        stage(1, 6'd8, rnd_row(), 1);
        commit();
        wait_drain();

        // tpu_done pulse with two rows queued
        mode = 1;
        cycles(1);
        dd_rise_cyc = -1;
        stage(0, 6'd11, rnd_row(), 1);
        stage(2, 6'd12, rnd_row(), 1);
        commit();
        tpu_done = 1;
        cycles(1);
        tpu_done = 0;
        wait_drain();
        cycles(4);
        chk("t5_done_rise", dd_rise_cyc, last_xfer_cyc + 2);
        chk("t5_done_level", drain_done, 1'b1);

        // overflow on b while a row is stalled in the serialiser
        mode = 0;
        cycles(2);
        base = log_bank.size();
        stage(0, 6'd10, rnd_row(), 1);
        commit();
        cycles(2);
        for (int i = 0; i < 5; i++) begin
            stage(1, 6'(20 + i), rnd_row(), i < 4);
            commit();
        end
        cycles(1);
        chk("t4_ovf", ovf_err, 3'b010);
        chk("t4_done_low", drain_done, 1'b0);
        mode = 1;
        wait_drain();
        chk("t4_rows", log_bank.size() - base, 5);
        chk("t4_ovf_sticky", ovf_err, 3'b010);

        // reset mid-row with further rows queued
        stage(0, 6'd30, rnd_row(), 1);
        stage(1, 6'd31, rnd_row(), 1);
        stage(2, 6'd32, rnd_row(), 1);
        commit();
        n = 0;
        while (mbeat != 7 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("t6_reach_beat7", n < 200, 1'b1);
        #2 srstn = 0;
        #1;
        chk("t6_reset_outs", {m_valid, m_last, m_bank, m_addr, m_data,
                              ovf_err, drain_done}, '0);
        cycles(2);
        srstn = 1;
        cycles(5);
        chk("t6_fifo_flushed", m_valid, 1'b0);
        base = log_bank.size();
        stage(2, 6'd33, rnd_row(), 1);
        commit();
        t1e0 = e0;
        wait_drain();
        chk("t6_new_bank", logb(base), 2);
        chk("t6_new_latency", logc(base), t1e0 + 1);

        // random traffic with random back-pressure, no overflow allowed
        mode = 3;
        cycles(1);
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 2) == 0 && exp_q[c].size() < FD)
                    stage(c, 6'($urandom), rnd_row(), 1);
            end
            commit();
        end
        tpu_done = 1;
        cycles(1);
        tpu_done = 0;
        wait_drain();
        cycles(3);
        chk("rand_done", drain_done, 1'b1);
        chk("rand_no_ovf", ovf_err, 3'b000);
        stage(1, 6'd44, rnd_row(), 1);
        commit();
        chk("done_drop_on_wr", drain_done, 1'b0);
        wait_drain();
        cycles(3);
        chk("done_reassert", drain_done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
